// File: rtl/hpu_pkg.sv
// rtl/hpu_pkg.sv - shared state type and buffer width helpers for the agu read stream
package hpu_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rs_state_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy needs one extra bit so that "full" is distinguishable from "empty".
  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, power-of-2 depth
module sync_fifo
  import hpu_pkg::*;
#(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop && !empty;
  // A full FIFO may still take a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/agu_rd_stream.sv
// rtl/agu_rd_stream.sv - turns agu addresses into BRAM reads and streams the data out
module agu_rd_stream
  import hpu_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          agu_en,
  input  logic [AW-1:0] agu_addr,
  input  logic          agu_last,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done
);

  localparam int CW = cnt_w(DEPTH);

  rs_state_t         state_q, state_d;
  logic              done_q, done_d;
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [RD_LAT-1:0] pl_q, pl_d;
  logic [CW:0]       inflight, credit_need;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full;
  logic [DW:0]       fifo_head;
  logic              issue_req, credit_ok, pop, last_beat;

  // Credits use registered occupancy only; a pop in this cycle is not credited
  // until the next one, which costs one bubble at full but keeps timing short.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + (CW+1)'(pv_q[i]);
    credit_need = inflight + (CW+1)'(fifo_count) + (CW+1)'(1);
    credit_ok   = !fifo_full && (credit_need <= (CW+1)'(DEPTH));
  end

  assign issue_req = ((state_q == IDLE) && start) || (state_q == ISSUE);
  assign agu_en    = issue_req && credit_ok;
  assign mem_en    = agu_en;
  assign mem_addr  = agu_addr;

  always_comb begin
    pv_d    = '0;
    pl_d    = '0;
    pv_d[0] = agu_en;
    pl_d[0] = agu_en && agu_last;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pl_d[i] = pl_q[i-1];
    end
  end

  sync_fifo #(.W(DW + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pv_q[RD_LAT-1]),
    .wdata ({pl_q[RD_LAT-1], mem_rdata}),
    .pop   (pop),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_head[DW-1:0];
  assign m_last    = fifo_head[DW] && m_valid;
  assign pop       = m_valid && m_ready;
  assign last_beat = pop && m_last;

  // A single-address run issues its only read on the start cycle and skips ISSUE.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = (agu_en && agu_last) ? DRAIN : ISSUE;
      ISSUE:   if (agu_en && agu_last) state_d = DRAIN;
      DRAIN:   if (last_beat) begin
                 state_d = IDLE;
                 done_d  = 1'b1;
               end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      pv_q    <= '0;
      pl_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_agu_rd_stream.sv
// tb/tb_agu_rd_stream.sv - directed self-checking bench for agu_rd_stream
module tb_agu_rd_stream;

  int tests = 0;
  int failed = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] mem [256];

  function automatic logic [31:0] pat(input int a);
    return (a >= 100) ? (32'hC0DE0000 ^ 32'(a * 7)) : 32'(a * 3);
  endfunction

  // Instance 1: RD_LAT=1
  logic        start1, agu_en1, agu_last1, mem_en1, m_valid1, m_last1, m_ready1, busy1, done1;
  logic [31:0] agu_addr1, mem_addr1, mem_rdata1, m_data1, ini1, fin1, cur1, rd1_q;

  assign agu_addr1  = start1 ? ini1 : cur1;
  assign agu_last1  = agu_en1 && (agu_addr1 == fin1);
  assign mem_rdata1 = rd1_q;

  always @(posedge clk) begin
    if (rst)          cur1 <= ini1;
    else if (start1)  cur1 <= agu_en1 ? ini1 + 32'd1 : ini1;
    else if (agu_en1) cur1 <= cur1 + 32'd1;
    if (mem_en1) rd1_q <= mem[mem_addr1[7:0]];
  end

  agu_rd_stream #(.AW(32), .DW(32), .RD_LAT(1), .DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .agu_en(agu_en1), .agu_addr(agu_addr1),
    .agu_last(agu_last1), .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1),
    .m_valid(m_valid1), .m_data(m_data1), .m_last(m_last1), .m_ready(m_ready1),
    .busy(busy1), .done(done1)
  );

  // Instance 3: RD_LAT=3
  logic        start3, agu_en3, agu_last3, mem_en3, m_valid3, m_last3, m_ready3, busy3, done3;
  logic [31:0] agu_addr3, mem_addr3, mem_rdata3, m_data3, ini3, fin3, cur3;
  logic [31:0] rd3_q [3];

  assign agu_addr3  = start3 ? ini3 : cur3;
  assign agu_last3  = agu_en3 && (agu_addr3 == fin3);
  assign mem_rdata3 = rd3_q[2];

  always @(posedge clk) begin
    if (rst)          cur3 <= ini3;
    else if (start3)  cur3 <= agu_en3 ? ini3 + 32'd1 : ini3;
    else if (agu_en3) cur3 <= cur3 + 32'd1;
    rd3_q[0] <= mem[mem_addr3[7:0]];
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end

  agu_rd_stream #(.AW(32), .DW(32), .RD_LAT(3), .DEPTH(4)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .agu_en(agu_en3), .agu_addr(agu_addr3),
    .agu_last(agu_last3), .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3),
    .m_valid(m_valid3), .m_data(m_data3), .m_last(m_last3), .m_ready(m_ready3),
    .busy(busy3), .done(done3)
  );

  task automatic test_reset;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; m_ready1 = 1'b0; m_ready3 = 1'b0;
    ini1 = 0; fin1 = 0; ini3 = 0; fin3 = 0;
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
    repeat (3) @(negedge clk);
    #1;
    tests++; if (m_valid1 !== 1'b0) begin failed++; $display("FAIL reset_m_valid1: got %b want 0", m_valid1); end
    tests++; if (m_last1 !== 1'b0) begin failed++; $display("FAIL reset_m_last1: got %b want 0", m_last1); end
    tests++; if (busy1 !== 1'b0) begin failed++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    tests++; if (done1 !== 1'b0) begin failed++; $display("FAIL reset_done1: got %b want 0", done1); end
    tests++; if (agu_en1 !== 1'b0 || mem_en1 !== 1'b0) begin failed++; $display("FAIL reset_en1: agu_en=%b mem_en=%b want 0 0", agu_en1, mem_en1); end
    tests++; if (m_valid3 !== 1'b0 || busy3 !== 1'b0) begin failed++; $display("FAIL reset_inst3: m_valid=%b busy=%b want 0 0", m_valid3, busy3); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int beats, dones, first_c, last_c, done_c;
    logic busy_at_done;
    ini1 = 0; fin1 = 7; m_ready1 = 1'b1;
    beats = 0; dones = 0; first_c = -1; last_c = -1; done_c = -1; busy_at_done = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); start1 = (c == 0); #1;
      if (c == 0) begin
        tests++;
        if (agu_en1 !== 1'b1 || mem_en1 !== 1'b1 || mem_addr1 !== 32'd0) begin
          failed++; $display("FAIL basic_start_issue: agu_en=%b mem_en=%b addr=%0d want 1 1 0", agu_en1, mem_en1, mem_addr1);
        end
      end
      if (m_valid1 && m_ready1) begin
        tests++;
        if (m_data1 !== pat(beats) || m_last1 !== (beats == 7)) begin
          failed++; $display("FAIL basic_beat%0d: data=%h last=%b want %h %b", beats, m_data1, m_last1, pat(beats), beats == 7);
        end
        if (first_c < 0) first_c = c;
        last_c = c; beats++;
      end
      if (done1) begin dones++; done_c = c; busy_at_done = busy1; end
    end
    tests++; if (first_c != 2 || last_c != 9 || beats != 8) begin failed++; $display("FAIL basic_timing: first=%0d last=%0d beats=%0d want 2 9 8", first_c, last_c, beats); end
    tests++; if (dones != 1 || done_c != 10) begin failed++; $display("FAIL basic_done: count=%0d cycle=%0d want 1 10", dones, done_c); end
    tests++; if (busy_at_done !== 1'b0) begin failed++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
  endtask

  task automatic test_single;
    int beats, dones, en_cycles;
    ini1 = 5; fin1 = 5; m_ready1 = 1'b1; mem[5] = 32'hA5;
    beats = 0; dones = 0; en_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); start1 = (c == 0); #1;
      if (agu_en1) en_cycles++;
      if (m_valid1 && m_ready1) begin
        tests++;
        if (m_data1 !== 32'hA5 || m_last1 !== 1'b1) begin
          failed++; $display("FAIL single_beat: data=%h last=%b want a5 1", m_data1, m_last1);
        end
        beats++;
      end
      if (done1) dones++;
    end
    mem[5] = pat(5);
    tests++; if (en_cycles != 1) begin failed++; $display("FAIL single_en_cycles: got %0d want 1", en_cycles); end
    tests++; if (beats != 1 || dones != 1) begin failed++; $display("FAIL single_counts: beats=%0d done=%0d want 1 1", beats, dones); end
  endtask

  task automatic test_backpressure;
    int beats, dones, issues, max_out, last_c;
    ini1 = 0; fin1 = 15;
    beats = 0; dones = 0; issues = 0; max_out = 0; last_c = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); start1 = (c == 0); m_ready1 = (c >= 20); #1;
      if (agu_en1) issues++;
      if (c == 19) begin
        tests++;
        if (agu_en1 !== 1'b0 || issues != 4) begin
          failed++; $display("FAIL bp_stall_issue: agu_en=%b issued=%0d want 0 4", agu_en1, issues);
        end
      end
      if (m_valid1 && m_ready1) begin
        tests++;
        if (m_data1 !== pat(beats) || m_last1 !== (beats == 15)) begin
          failed++; $display("FAIL bp_beat%0d: data=%h last=%b want %h %b", beats, m_data1, m_last1, pat(beats), beats == 15);
        end
        beats++; last_c = c;
      end
      if (issues - beats > max_out) max_out = issues - beats;
      if (done1) dones++;
    end
    tests++; if (max_out > 4) begin failed++; $display("FAIL bp_occupancy: max outstanding %0d want <= 4", max_out); end
    tests++; if (beats != 16 || last_c != 35 || dones != 1) begin failed++; $display("FAIL bp_drain: beats=%0d last_cycle=%0d done=%0d want 16 35 1", beats, last_c, dones); end
  endtask

  task automatic test_random;
    int beats, dones, c;
    logic held, held_last;
    logic [31:0] held_data;
    ini3 = 100; fin3 = 163;
    beats = 0; dones = 0; held = 1'b0; held_last = 1'b0; held_data = '0;
    for (c = 0; c < 3000 && dones == 0; c++) begin
      @(negedge clk); start3 = (c == 0); m_ready3 = 1'($urandom_range(0, 1)); #1;
      if (held) begin
        tests++;
        if (m_valid3 !== 1'b1 || m_data3 !== held_data || m_last3 !== held_last) begin
          failed++; $display("FAIL rand_hold: valid=%b data=%h last=%b want 1 %h %b", m_valid3, m_data3, m_last3, held_data, held_last);
        end
      end
      if (m_valid3 && m_ready3) begin
        tests++;
        if (m_data3 !== pat(100 + beats) || m_last3 !== (beats == 63)) begin
          failed++; $display("FAIL rand_beat%0d: data=%h last=%b want %h %b", beats, m_data3, m_last3, pat(100 + beats), beats == 63);
        end
        beats++;
      end
      held = m_valid3 && !m_ready3; held_data = m_data3; held_last = m_last3;
      if (done3) dones++;
    end
    start3 = 1'b0; m_ready3 = 1'b0;
    tests++; if (beats != 64 || dones != 1) begin failed++; $display("FAIL rand_counts: beats=%0d done=%0d want 64 1", beats, dones); end
  endtask

  task automatic test_reset_mid;
    int beats, dones, c;
    ini1 = 0; fin1 = 31; m_ready1 = 1'b1; beats = 0;
    for (c = 0; c < 60 && beats < 5; c++) begin
      @(negedge clk); start1 = (c == 0); #1;
      if (m_valid1 && m_ready1) begin
        tests++;
        if (m_data1 !== pat(beats)) begin failed++; $display("FAIL rmid_pre_beat%0d: data=%h want %h", beats, m_data1, pat(beats)); end
        beats++;
      end
    end
    tests++; if (beats != 5) begin failed++; $display("FAIL rmid_pre_count: got %0d want 5", beats); end
    @(negedge clk); start1 = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    tests++;
    if (m_valid1 !== 1'b0 || busy1 !== 1'b0 || agu_en1 !== 1'b0) begin
      failed++; $display("FAIL rmid_cleared: m_valid=%b busy=%b agu_en=%b want 0 0 0", m_valid1, busy1, agu_en1);
    end
    rst = 1'b0;
    beats = 0; dones = 0;
    for (c = 0; c < 80; c++) begin
      @(negedge clk); start1 = (c == 0); #1;
      if (m_valid1 && m_ready1) begin
        tests++;
        if (m_data1 !== pat(beats) || m_last1 !== (beats == 31)) begin
          failed++; $display("FAIL rmid_beat%0d: data=%h last=%b want %h %b", beats, m_data1, m_last1, pat(beats), beats == 31);
        end
        beats++;
      end
      if (done1) dones++;
    end
    tests++; if (beats != 32 || dones != 1) begin failed++; $display("FAIL rmid_counts: beats=%0d done=%0d want 32 1", beats, dones); end
  endtask

  task automatic test_start_busy;
    int beats, dones, issues, pulse_c;
    ini1 = 0; fin1 = 7; m_ready1 = 1'b1;
    beats = 0; dones = 0; issues = 0; pulse_c = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); start1 = (c == 0) || (c == pulse_c); #1;
      if (c == pulse_c) begin
        tests++;
        if (busy1 !== 1'b1 || agu_en1 !== 1'b0) begin
          failed++; $display("FAIL sbusy_pulse: busy=%b agu_en=%b want 1 0", busy1, agu_en1);
        end
      end
      if (agu_en1) issues++;
      if (agu_en1 && agu_last1) pulse_c = c + 1;
      if (m_valid1 && m_ready1) begin
        tests++;
        if (m_data1 !== pat(beats) || m_last1 !== (beats == 7)) begin
          failed++; $display("FAIL sbusy_beat%0d: data=%h last=%b want %h %b", beats, m_data1, m_last1, pat(beats), beats == 7);
        end
        beats++;
      end
      if (done1) dones++;
    end
    start1 = 1'b0;
    tests++; if (beats != 8 || dones != 1 || issues != 8) begin failed++; $display("FAIL sbusy_counts: beats=%0d done=%0d issued=%0d want 8 1 8", beats, dones, issues); end
    tests++; if (busy1 !== 1'b0 || pulse_c < 0) begin failed++; $display("FAIL sbusy_idle: busy=%b pulse_cycle=%0d want 0 >=0", busy1, pulse_c); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_start_busy();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
